// File: rtl/t02_keypad_pkg.sv
// Shared types and constants for the t02 keypad scanner and its key queue.
package t02_keypad_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, PRESSED} t02_kp_state_t;

  typedef logic [3:0] t02_key_code_t;

  // Rows are active-low; the lowest-numbered low row wins when several are pressed.
  function automatic logic [1:0] lowest_low_row(input logic [KP_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KP_ROWS; i++) begin
      if (!rows[KP_ROWS-1-i]) idx = 2'(KP_ROWS-1-i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/t02_key_fifo.sv
// Key queue: circular FIFO of DEPTH entries when T02_KEYPAD_FIFO_EN is defined,
// otherwise a single holding register. Tracks a sticky overrun flag.
module t02_key_fifo
  import t02_keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  t02_key_code_t push_data,
  input  logic          pop,
  output t02_key_code_t head,
  output logic          empty,
  output logic          full,
  output logic          overrun
);

  logic pop_ok;
  logic push_ok;
  logic drop;

  // A pop frees a slot in the same cycle, so push is accepted even when full.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (pop_ok) begin
      overrun <= 1'b0;
    end
  end

`ifdef T02_KEYPAD_FIFO_EN
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  t02_key_code_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
`else
  t02_key_code_t head_q;
  logic          valid_q;

  assign empty = ~valid_q;
  assign full  = valid_q;
  assign head  = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      valid_q <= 1'b0;
    end else if (push_ok) begin
      head_q  <= push_data;
      valid_q <= 1'b1;
    end else if (pop_ok) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/t02_keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a CPU key queue.
// Queue depth is FIFO_DEPTH when T02_KEYPAD_FIFO_EN is defined, else a single register.
module t02_keypad_scanner
  import t02_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [KP_ROWS-1:0]   read_row,
  output logic [KP_COLS-1:0]   scan_col,
  output logic [3:0]           key_code,
  output logic                 key_valid,
  input  logic                 key_ack,
  output logic                 key_pressed,
  output logic                 overrun
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DBC_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DBC_W-1:0] DBC_DONE = DBC_W'(DEBOUNCE_CNT);
  localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);

  logic [KP_ROWS-1:0] row_meta;
  logic [KP_ROWS-1:0] rows;

  t02_kp_state_t      state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [1:0]         row_q, row_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DBC_W-1:0]   dbc_q, dbc_d;
  logic [DBC_W-1:0]   rel_q, rel_d;
  logic               tick;
  logic               push;
  t02_key_code_t      push_code;
  logic               q_empty;
  logic               q_full;

  // Rows idle high (pulled up), so the synchroniser resets to all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '1;
      rows     <= '1;
    end else begin
      row_meta <= read_row;
      rows     <= row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      div_q   <= '0;
      dbc_q   <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      dbc_q   <= dbc_d;
      rel_q   <= rel_d;
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    dbc_d   = dbc_q;
    rel_d   = rel_q;
    push    = 1'b0;

    if (!en) begin
      state_d = IDLE;
      div_d   = '0;
      dbc_d   = '0;
      rel_d   = '0;
    end else begin
      if (state_q != IDLE) div_d = tick ? '0 : div_q + DIV_W'(1);

      unique case (state_q)
        IDLE: begin
          state_d = SCAN;
          col_d   = '0;
          div_d   = '0;
        end
        SCAN: begin
          if (tick) begin
            if (&rows) begin
              col_d = col_q + 2'd1;
            end else begin
              row_d = lowest_low_row(rows);
              // With a single-tick debounce the first sighting is already stable.
              if (DBC_ONE == DBC_DONE) begin
                push    = 1'b1;
                dbc_d   = '0;
                state_d = PRESSED;
              end else begin
                dbc_d   = DBC_ONE;
                state_d = DEBOUNCE;
              end
            end
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (!rows[row_q]) begin
              if ((dbc_q + DBC_ONE) == DBC_DONE) begin
                push    = 1'b1;
                dbc_d   = '0;
                state_d = PRESSED;
              end else begin
                dbc_d = dbc_q + DBC_ONE;
              end
            end else begin
              dbc_d   = '0;
              state_d = SCAN;
            end
          end
        end
        PRESSED: begin
          if (tick) begin
            if (rows[row_q]) begin
              if ((rel_q + DBC_ONE) == DBC_DONE) begin
                rel_d   = '0;
                col_d   = col_q + 2'd1;
                state_d = SCAN;
              end else begin
                rel_d = rel_q + DBC_ONE;
              end
            end else begin
              rel_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push_code   = {row_d, col_q};
  assign scan_col    = (state_q == IDLE) ? 4'hF : ~(4'b0001 << col_q);
  assign key_pressed = (state_q == PRESSED);
  assign key_valid   = ~q_empty;

  t02_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_code),
    .pop       (key_ack),
    .head      (key_code),
    .empty     (q_empty),
    .full      (q_full),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_t02_keypad_scanner.sv
// Self-checking bench for t02_keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=2) with a keypad and queue model.
module tb_t02_keypad_scanner;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 2;
  localparam int unsigned FIFO_DEPTH   = 4;
`ifdef T02_KEYPAD_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] read_row;
  logic [3:0] scan_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_pressed;
  logic       overrun;

  logic       key_down;
  logic [1:0] key_r;
  logic [1:0] key_c;

  int  checks;
  int  failures;
  bit  tmo;

  logic [3:0] obs_col  [17];
  logic [3:0] obs_code [17];
  logic       obs_kv   [17];
  logic       obs_kp   [17];

  logic [3:0] mq[$];
  bit         movr;

  t02_keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .read_row    (read_row),
    .scan_col    (scan_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_pressed (key_pressed),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Keypad: a held key shorts its row to its column, pulling the row low while that column is driven.
  always_comb begin
    read_row = 4'hF;
    if (key_down && !scan_col[key_c]) read_row[key_r] = 1'b0;
  end

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Queue model: pop is taken first, so a same-cycle push always fits.
  task automatic model_step(input bit push, input logic [3:0] code, input bit pop);
    bit pop_ok;
    bit was_full;
    pop_ok   = pop && (mq.size() > 0);
    was_full = (mq.size() == CAP);
    if (pop_ok) begin
      void'(mq.pop_front());
      movr = 1'b0;
    end
    if (push) begin
      if (!was_full || pop_ok) mq.push_back(code);
      else movr = 1'b1;
    end
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    model_step(1'b0, 4'h0, 1'b1);
  endtask

  task automatic wait_fresh_col(input logic [1:0] c);
    logic [3:0] target;
    int n;
    target = col_drive(c);
    n = 0;
    while (scan_col == target && n < 200) begin @(negedge clk); n++; end
    while (scan_col != target && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo = 1'b1;
  endtask

  // Presses (r,c) on the first negedge its column is driven, then records outputs for 17 negedges.
  task automatic press_seq(input logic [1:0] r, input logic [1:0] c,
                           input int rel_k, input int ack_k, input int en_k);
    wait_fresh_col(c);
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      obs_col[k]  = scan_col;
      obs_code[k] = key_code;
      obs_kv[k]   = key_valid;
      obs_kp[k]   = key_pressed;
      if (k == ack_k)     key_ack  = 1'b1;
      if (k == ack_k + 1) key_ack  = 1'b0;
      if (k == rel_k)     key_down = 1'b0;
      if (k == en_k)      en       = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [1:0] r, c;
    rst = 1'b1; en = 1'b0; key_ack = 1'b0; key_down = 1'b0; key_r = '0; key_c = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (scan_col !== 4'hF || key_code !== 4'h0 || key_valid !== 1'b0 ||
        key_pressed !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state scan_col=%h key_code=%h valid=%b pressed=%b overrun=%b required F/0/0/0/0",
               scan_col, key_code, key_valid, key_pressed, overrun);
    end
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    checks++;
    if (scan_col !== 4'hE) begin
      failures++; $display("FAIL enable_start scan_col=%h required e", scan_col);
    end
    for (int i = 0; i < CAP; i++) begin
      r = 2'($urandom_range(3)); c = 2'($urandom_range(3));
      press_seq(r, c, 8, -10, -10);
      model_step(1'b1, {r, c}, 1'b0);
    end
    r = 2'($urandom_range(3)); c = 2'($urandom_range(3));
    wait_fresh_col(c);
    key_r = r; key_c = c; key_down = 1'b1;
    repeat (10) @(negedge clk);
    model_step(1'b1, {r, c}, 1'b0);
    checks++;
    if (key_pressed !== 1'b1 || key_valid !== 1'b1 || overrun !== movr || key_code !== mq[0]) begin
      failures++;
      $display("FAIL pre_reset pressed=%b valid=%b overrun=%b code=%h required 1/1/%b/%h",
               key_pressed, key_valid, overrun, key_code, movr, mq[0]);
    end
    rst = 1'b1;
    #1;
    mq.delete(); movr = 1'b0;
    checks++;
    if (scan_col !== 4'hF || key_valid !== 1'b0 || overrun !== 1'b0 ||
        key_pressed !== 1'b0 || key_code !== 4'h0) begin
      failures++;
      $display("FAIL async_reset scan_col=%h valid=%b overrun=%b pressed=%b code=%h required F/0/0/0/0",
               scan_col, key_valid, overrun, key_pressed, key_code);
    end
    key_down = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (scan_col !== 4'hE) begin
      failures++; $display("FAIL reset_restart scan_col=%h required e", scan_col);
    end
    checks++;
    if (tmo) begin failures++; $display("FAIL reset_timeout waited=1 required 0"); tmo = 1'b0; end
  endtask

  task automatic test_clean_press();
    logic [1:0] r, c;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin r = 2'd1; c = 2'd2; end
      else begin r = 2'($urandom_range(3)); c = 2'($urandom_range(3)); end
      press_seq(r, c, 8, -10, -10);
      model_step(1'b1, {r, c}, 1'b0);
      checks++;
      if (tmo) begin failures++; $display("FAIL press_timeout key=%h", {r, c}); tmo = 1'b0; end
      checks++;
      if (obs_kv[7] !== 1'b0 || obs_kv[8] !== 1'b1 || obs_code[8] !== mq[0]) begin
        failures++;
        $display("FAIL press_push valid7=%b valid8=%b code=%h required 0/1/%h",
                 obs_kv[7], obs_kv[8], obs_code[8], mq[0]);
      end
      checks++;
      if (obs_kp[7] !== 1'b0 || obs_kp[8] !== 1'b1 || obs_kp[15] !== 1'b1 || obs_kp[16] !== 1'b0) begin
        failures++;
        $display("FAIL press_level pressed7/8/15/16=%b%b%b%b required 0110",
                 obs_kp[7], obs_kp[8], obs_kp[15], obs_kp[16]);
      end
      checks++;
      if (obs_col[15] !== col_drive(c) || obs_col[16] !== col_drive(c + 2'd1)) begin
        failures++;
        $display("FAIL release_next_col col15=%h col16=%h required %h/%h",
                 obs_col[15], obs_col[16], col_drive(c), col_drive(c + 2'd1));
      end
      do_ack();
      checks++;
      if (key_valid !== 1'b0) begin
        failures++; $display("FAIL press_ack valid=%b required 0", key_valid);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] r, c;
    bit bad;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin r = 2'd0; c = 2'd0; end
      else begin r = 2'($urandom_range(3)); c = 2'($urandom_range(3)); end
      press_seq(r, c, 4, -10, -10);
      bad = 1'b0;
      for (int k = 0; k <= 16; k++) if (obs_kv[k] !== 1'b0 || obs_kp[k] !== 1'b0) bad = 1'b1;
      checks++;
      if (bad || tmo) begin
        failures++; $display("FAIL bounce_no_push push_or_timeout=1 key=%h required 0", {r, c});
        tmo = 1'b0;
      end
      checks++;
      if (obs_col[11] !== col_drive(c) || obs_col[12] !== col_drive(c + 2'd1)) begin
        failures++;
        $display("FAIL bounce_col col11=%h col12=%h required %h/%h",
                 obs_col[11], obs_col[12], col_drive(c), col_drive(c + 2'd1));
      end
    end
  endtask

  task automatic test_overrun();
    int n;
    for (int i = 0; i <= CAP; i++) begin
      press_seq(2'((i + 1) >> 2), 2'((i + 1) & 3), 8, -10, -10);
      model_step(1'b1, 4'(i + 1), 1'b0);
    end
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h1 || overrun !== 1'b1 || tmo) begin
      failures++;
      $display("FAIL overrun_flag valid=%b code=%h overrun=%b timeout=%b required 1/1/1/0",
               key_valid, key_code, overrun, tmo);
      tmo = 1'b0;
    end
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== mq[0]) begin
        failures++;
        $display("FAIL overrun_order idx=%0d valid=%b code=%h required 1/%h", i, key_valid, key_code, mq[0]);
      end
      do_ack();
      checks++;
      if (overrun !== movr) begin
        failures++; $display("FAIL overrun_clear idx=%0d overrun=%b required %b", i, overrun, movr);
      end
    end
    checks++;
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL overrun_drained valid=%b required 0", key_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r, c;
    int n;
    for (int i = 0; i < CAP; i++) begin
      r = 2'($urandom_range(3)); c = 2'($urandom_range(3));
      press_seq(r, c, 8, -10, -10);
      model_step(1'b1, {r, c}, 1'b0);
    end
    r = 2'($urandom_range(3)); c = 2'($urandom_range(3));
    press_seq(r, c, 8, 7, -10);
    model_step(1'b1, {r, c}, 1'b1);
    checks++;
    if (obs_kv[8] !== 1'b1 || obs_code[8] !== mq[0] || overrun !== 1'b0 || tmo) begin
      failures++;
      $display("FAIL push_pop_full valid=%b code=%h overrun=%b timeout=%b required 1/%h/0/0",
               obs_kv[8], obs_code[8], overrun, tmo, mq[0]);
      tmo = 1'b0;
    end
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== mq[0]) begin
        failures++;
        $display("FAIL b2b_order idx=%0d valid=%b code=%h required 1/%h", i, key_valid, key_code, mq[0]);
      end
      do_ack();
    end
    checks++;
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_count valid=%b required 0 after %0d acks", key_valid, n);
    end
  endtask

  task automatic test_enable_drop();
    logic [1:0] r, c;
    bit bad;
    r = 2'($urandom_range(3)); c = 2'($urandom_range(3));
    press_seq(r, c, 8, -10, -10);
    model_step(1'b1, {r, c}, 1'b0);
    r = 2'($urandom_range(3)); c = 2'($urandom_range(3));
    press_seq(r, c, 8, -10, 5);
    checks++;
    if (obs_col[5] !== col_drive(c) || obs_col[6] !== 4'hF || tmo) begin
      failures++;
      $display("FAIL en_drop_col col5=%h col6=%h timeout=%b required %h/f/0",
               obs_col[5], obs_col[6], tmo, col_drive(c));
      tmo = 1'b0;
    end
    bad = 1'b0;
    for (int k = 0; k <= 16; k++) if (obs_kp[k] !== 1'b0) bad = 1'b1;
    checks++;
    if (bad || key_valid !== 1'b1 || key_code !== mq[0]) begin
      failures++;
      $display("FAIL en_drop_queue pressed_seen=%b valid=%b code=%h required 0/1/%h",
               bad, key_valid, key_code, mq[0]);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (scan_col !== 4'hE) begin
      failures++; $display("FAIL en_resume scan_col=%h required e", scan_col);
    end
    do_ack();
    checks++;
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL en_drop_ack valid=%b required 0", key_valid);
    end
  endtask

  initial begin
    checks = 0; failures = 0; tmo = 1'b0; movr = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_overrun();
    test_back_to_back();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
